// File: rtl/instr_encoder_pkg.sv
// Shared encoder definitions: format codes, NOP word, FSM state codes,
// encode-request payload and the immediate range helper.
package instr_encoder_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CNT_W   = 9;

  localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_FULL = 2'd2
  } state_e;

  // fmt is kept as raw bits so invalid codes can be carried and flagged
  typedef struct packed {
    logic [2:0]         fmt;
    logic [6:0]         opcode;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [INSTR_W-1:0] imm;
  } enc_req_t;

  // True when v is the sign-extension of its low 'bits' bits
  function automatic logic fits_signed(input logic [INSTR_W-1:0] v, input int unsigned bits);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < INSTR_W; i++) begin
      if ((i + 1 >= bits) && (v[i] != v[INSTR_W-1])) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational field -> RV32I word packer.
// Ports: req_i (encode request payload), word_c_o (packed word, NOP when bad),
//        bad_c_o (invalid format or, with ENC_IMM_CHECK_EN, out-of-range immediate).
// Macro: ENC_IMM_CHECK_EN enables immediate range checking.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  enc_req_t           req_i,
  output logic [INSTR_W-1:0] word_c_o,
  output logic               bad_c_o
);

  logic [INSTR_W-1:0] raw;
  logic               fmt_ok;
  logic               imm_ok;

  // Field placement per instruction format
  always_comb begin
    raw    = INSTR_NOP;
    fmt_ok = 1'b1;
    case (req_i.fmt)
      FMT_R: raw = {req_i.funct7, req_i.rs2, req_i.rs1, req_i.funct3, req_i.rd, req_i.opcode};
      FMT_I: raw = {req_i.imm[11:0], req_i.rs1, req_i.funct3, req_i.rd, req_i.opcode};
      FMT_S: raw = {req_i.imm[11:5], req_i.rs2, req_i.rs1, req_i.funct3, req_i.imm[4:0],
                    req_i.opcode};
      FMT_B: raw = {req_i.imm[12], req_i.imm[10:5], req_i.rs2, req_i.rs1, req_i.funct3,
                    req_i.imm[4:1], req_i.imm[11], req_i.opcode};
      FMT_U: raw = {req_i.imm[31:12], req_i.rd, req_i.opcode};
      FMT_J: raw = {req_i.imm[20], req_i.imm[10:1], req_i.imm[11], req_i.imm[19:12],
                    req_i.rd, req_i.opcode};
      default: fmt_ok = 1'b0;
    endcase
  end

`ifdef ENC_IMM_CHECK_EN
  // Immediate must be representable by the format's encoding
  always_comb begin
    imm_ok = 1'b1;
    case (req_i.fmt)
      FMT_I, FMT_S: imm_ok = fits_signed(req_i.imm, 12);
      FMT_B:        imm_ok = fits_signed(req_i.imm, 13) && !req_i.imm[0];
      FMT_J:        imm_ok = fits_signed(req_i.imm, 21) && !req_i.imm[0];
      FMT_U:        imm_ok = (req_i.imm[11:0] == 12'h000);
      default:      imm_ok = 1'b1;
    endcase
  end
`else
  assign imm_ok = 1'b1;
`endif

  assign bad_c_o  = !fmt_ok || !imm_ok;
  assign word_c_o = bad_c_o ? INSTR_NOP : raw;

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: sequential RV32I encoder / IMEM program loader.
// Accepts field-level requests on req_valid/req_ready, packs them and writes
// the word to IMEM at an auto-incrementing address (one-entry pipeline).
// Ports: clk, rst_n (async active-low), load_base/base_addr (session start),
//        req_* (encode request), imem_wr_en/imem_wr_ready/imem_addr/imem_wr_data
//        (IMEM write port), count/full/err (session status).
// Macro: ENC_IMM_CHECK_EN (immediate range checking inside instr_pack).
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MAX_INSTR = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_base,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_fmt,
  input  logic [6:0]         req_opcode,
  input  logic [4:0]         req_rd,
  input  logic [4:0]         req_rs1,
  input  logic [4:0]         req_rs2,
  input  logic [2:0]         req_funct3,
  input  logic [6:0]         req_funct7,
  input  logic [INSTR_W-1:0] req_imm,
  output logic               imem_wr_en,
  input  logic               imem_wr_ready,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wr_data,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               err
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INSTR);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  next_addr_q, next_addr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               err_q, err_d;

  enc_req_t           req;
  logic [INSTR_W-1:0] word_c;
  logic               bad_c;
  logic [ADDR_W-1:0]  base_aligned;
  logic               accept;
  logic               wr_done;

  assign req = {req_fmt, req_opcode, req_rd, req_rs1, req_rs2, req_funct3, req_funct7, req_imm};

  instr_pack u_pack (
    .req_i    (req),
    .word_c_o (word_c),
    .bad_c_o  (bad_c)
  );

  assign base_aligned = base_addr & ~ADDR_W'(3);
  assign full         = (count_q == CNT_MAX);
  assign req_ready    = !full && ((state_q == ST_IDLE) || ((state_q == ST_PEND) && imem_wr_ready));
  assign accept       = req_valid && req_ready;
  assign wr_done      = (state_q == ST_PEND) && imem_wr_ready;

  // Next-state: load_base applies first so a same-cycle accept starts at base
  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    count_d     = count_q;
    err_d       = err_q;
    if (load_base) begin
      next_addr_d = base_aligned;
      count_d     = '0;
      err_d       = 1'b0;
    end
    if (accept) begin
      addr_d      = next_addr_d;
      data_d      = word_c;
      next_addr_d = next_addr_d + ADDR_W'(4);
      count_d     = count_d + CNT_W'(1);
      if (bad_c) err_d = 1'b1;
      state_d     = ST_PEND;
    end else if (wr_done) begin
      state_d = (count_d == CNT_MAX) ? ST_FULL : ST_IDLE;
    end else if ((state_q == ST_FULL) && load_base) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      next_addr_q <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      count_q     <= count_d;
      err_q       <= err_d;
    end
  end

  assign imem_wr_en   = (state_q == ST_PEND);
  assign imem_addr    = addr_q;
  assign imem_wr_data = data_q;
  assign count        = count_q;
  assign err          = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder (MAX_INSTR reduced to 4 for the FULL path).
// Macro: ENC_IMM_CHECK_EN selects the expected result of the out-of-range addi.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int unsigned ADDR_W = 10;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               load_base;
  logic [ADDR_W-1:0]  base_addr;
  logic               req_valid;
  logic               req_ready;
  logic [2:0]         req_fmt;
  logic [6:0]         req_opcode;
  logic [4:0]         req_rd;
  logic [4:0]         req_rs1;
  logic [4:0]         req_rs2;
  logic [2:0]         req_funct3;
  logic [6:0]         req_funct7;
  logic [31:0]        req_imm;
  logic               imem_wr_en;
  logic               imem_wr_ready;
  logic [ADDR_W-1:0]  imem_addr;
  logic [31:0]        imem_wr_data;
  logic [8:0]         count;
  logic               full;
  logic               err;

  int checks = 0;
  int errors = 0;

  instr_encoder #(.ADDR_W(ADDR_W), .MAX_INSTR(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_base     (load_base),
    .base_addr     (base_addr),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_fmt       (req_fmt),
    .req_opcode    (req_opcode),
    .req_rd        (req_rd),
    .req_rs1       (req_rs1),
    .req_rs2       (req_rs2),
    .req_funct3    (req_funct3),
    .req_funct7    (req_funct7),
    .req_imm       (req_imm),
    .imem_wr_en    (imem_wr_en),
    .imem_wr_ready (imem_wr_ready),
    .imem_addr     (imem_addr),
    .imem_wr_data  (imem_wr_data),
    .count         (count),
    .full          (full),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pending write: enable, address, data and session count
  task automatic chk_wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] c);
    chk({tag, "_en"},   32'(imem_wr_en), 32'd1);
    chk({tag, "_addr"}, 32'(imem_addr), a);
    chk({tag, "_data"}, imem_wr_data, d);
    chk({tag, "_cnt"},  32'(count), c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [31:0] imm);
    req_valid  = 1'b1;
    req_fmt    = f;
    req_opcode = op;
    req_rd     = rd;
    req_rs1    = rs1;
    req_rs2    = rs2;
    req_funct3 = f3;
    req_funct7 = f7;
    req_imm    = imm;
  endtask

  initial begin
    rst_n = 1'b0; load_base = 1'b0; base_addr = '0; req_valid = 1'b0;
    req_fmt = '0; req_opcode = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0;
    req_funct3 = '0; req_funct7 = '0; req_imm = '0; imem_wr_ready = 1'b1;
    #12;
    chk("rst_en",    32'(imem_wr_en), 32'd0);
    chk("rst_addr",  32'(imem_addr), 32'd0);
    chk("rst_data",  imem_wr_data, 32'd0);
    chk("rst_cnt",   32'(count), 32'd0);
    chk("rst_full",  32'(full), 32'd0);
    chk("rst_err",   32'(err), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // addi x1,x0,5
    req(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    tick();
    req_valid = 1'b0;
    chk_wr("addi", 32'h0, 32'h0050_0093, 32'd1);
    tick();
    chk("addi_done_en", 32'(imem_wr_en), 32'd0);

    // add then sw back-to-back from a fresh session at 0
    load_base = 1'b1; base_addr = '0;
    tick();
    load_base = 1'b0;
    chk("load0_cnt", 32'(count), 32'd0);
    req(FMT_R, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    tick();
    chk_wr("add", 32'h0, 32'h0020_81B3, 32'd1);
    chk("add_ready", 32'(req_ready), 32'd1);
    req(FMT_S, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    tick();
    req_valid = 1'b0;
    chk_wr("sw", 32'h4, 32'h0020_A423, 32'd2);
    tick();
    chk("sw_done_en", 32'(imem_wr_en), 32'd0);

    // beq, lui (stalled 3 cycles), jal, then invalid format filling the session
    load_base = 1'b1;
    tick();
    load_base = 1'b0;
    req(FMT_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
    tick();
    chk_wr("beq", 32'h0, 32'h0020_8463, 32'd1);
    req(FMT_U, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    tick();
    chk_wr("lui", 32'h4, 32'h1234_52B7, 32'd2);
    imem_wr_ready = 1'b0;
    req(FMT_J, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16);
    #1;
    chk("stall_ready0", 32'(req_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_wr("stall", 32'h4, 32'h1234_52B7, 32'd2);
      chk("stall_ready", 32'(req_ready), 32'd0);
    end
    imem_wr_ready = 1'b1;
    #1;
    chk("resume_ready", 32'(req_ready), 32'd1);
    tick();
    chk_wr("jal", 32'h8, 32'h0100_00EF, 32'd3);
    req(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    tick();
    req_valid = 1'b0;
    chk_wr("badfmt", 32'hC, 32'h0000_0013, 32'd4);
    chk("badfmt_err",   32'(err), 32'd1);
    chk("badfmt_full",  32'(full), 32'd1);
    chk("badfmt_ready", 32'(req_ready), 32'd0);
    tick();
    chk("fullst_en",    32'(imem_wr_en), 32'd0);
    chk("fullst_full",  32'(full), 32'd1);
    chk("fullst_ready", 32'(req_ready), 32'd0);

    // reload at 0x100 leaves FULL
    load_base = 1'b1; base_addr = 10'h100;
    tick();
    load_base = 1'b0;
    chk("reload_full",  32'(full), 32'd0);
    chk("reload_cnt",   32'(count), 32'd0);
    chk("reload_err",   32'(err), 32'd0);
    chk("reload_ready", 32'(req_ready), 32'd1);
    req(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    tick();
    req_valid = 1'b0;
    chk_wr("reload", 32'h100, 32'h0050_0093, 32'd1);
    tick();

    // same-cycle load_base + accept, misaligned base, then address wrap
    load_base = 1'b1; base_addr = 10'h3FE;
    req(FMT_R, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    tick();
    load_base = 1'b0;
    chk_wr("samecyc", 32'h3FC, 32'h0020_81B3, 32'd1);
    req(FMT_S, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    tick();
    req_valid = 1'b0;
    chk_wr("wrap", 32'h0, 32'h0020_A423, 32'd2);
    tick();

    // addi with 4096: out of 12-bit range
    req(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096);
    tick();
    req_valid = 1'b0;
`ifdef ENC_IMM_CHECK_EN
    chk_wr("immchk", 32'h4, 32'h0000_0013, 32'd3);
    chk("immchk_err", 32'(err), 32'd1);
`else
    chk_wr("immtrunc", 32'h4, 32'h0000_0093, 32'd3);
    chk("immtrunc_err", 32'(err), 32'd0);
`endif

    // reset while a word is pending
    imem_wr_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_en",   32'(imem_wr_en), 32'd0);
    chk("midrst_addr", 32'(imem_addr), 32'd0);
    chk("midrst_cnt",  32'(count), 32'd0);
    chk("midrst_data", imem_wr_data, 32'd0);
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
